// File: rtl/flopskid.sv
// flopskid: two-entry ready/valid register slice (skid buffer).
// Both the forward path (OutValid/OutData) and the backward path (InReady)
// come straight from flops, so no input reaches an output combinationally.
// The skid entry catches the one word already in flight when the consumer
// stalls, which keeps full throughput with a registered ready.
module flopskid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             FlushS,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Count
);

  // State encoding equals the number of held entries, so Count is the state.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // Handshakes use the registered flags, never the next-state logic.
  assign in_fire  = InValid & InReady;
  assign out_fire = OutValid & OutReady;
  assign OutData  = main_q;

  // Next occupancy; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (FlushS) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = TWO;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        TWO:     if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and output flags are registered from the next state so that
  // InReady/OutValid/Count are pure flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      OutValid <= 1'b0;
      InReady  <= 1'b1;
      Count    <= 2'd0;
    end else begin
      state_q  <= state_d;
      OutValid <= (state_d != EMPTY);
      InReady  <= (state_d != TWO);
      Count    <= state_d;
    end
  end

  // Data movement: load head, park in skid, or promote skid to head.
  // A flush leaves the data registers untouched; only the occupancy clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!FlushS) begin
      case (state_q)
        EMPTY: if (in_fire) main_q <= InData;
        ONE: begin
          if (in_fire) begin
            if (out_fire) main_q <= InData;
            else          skid_q <= InData;
          end
        end
        TWO:     if (out_fire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flopskid.sv
// Testbench for flopskid: directed scenarios followed by random traffic.
// The reference is a plain queue of at most two words; the monitor checks
// flags, occupancy and head word against it every cycle.
module tb_flopskid;

  logic       clk = 1'b0;
  logic       reset;
  logic       FlushS;
  logic       InValid;
  logic       InReady;
  logic [7:0] InData;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] OutData;
  logic [1:0] Count;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] sbq[$];

  flopskid #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .FlushS   (FlushS),
    .InValid  (InValid),
    .InReady  (InReady),
    .InData   (InData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .Count    (Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a FIFO of capacity two. Accept when not full, emit head when
  // non-empty and the consumer is ready; flush and reset empty it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sbq.delete();
    end else begin
      bit take_in, take_out;
      take_in  = InValid && (sbq.size() < 2);
      take_out = (sbq.size() > 0) && OutReady;
      if (FlushS) begin
        sbq.delete();
      end else begin
        if (take_out) void'(sbq.pop_front());
        if (take_in)  sbq.push_back(InData);
      end
    end
  end

  // Monitor: compare DUT state against the reference away from the edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("OutValid", OutValid, (sbq.size() > 0));
      chk("InReady",  InReady,  (sbq.size() < 2));
      chk("Count",    Count,    sbq.size());
      if (sbq.size() > 0) chk("OutData", OutData, sbq[0]);
    end
  end

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    InValid  = iv;
    InData   = d;
    OutReady = ordy;
    FlushS   = fl;
  endtask

  initial begin
    reset = 1'b1; FlushS = 1'b0; InValid = 1'b0; InData = 8'h00; OutReady = 1'b0;
    #1;
    chk("rst_OutValid", OutValid, 1'b0);
    chk("rst_InReady",  InReady,  1'b1);
    chk("rst_Count",    Count,    2'd0);
    chk("rst_OutData",  OutData,  8'h00);
    #11;
    reset = 1'b0;

    // Streaming 0x01..0x10 with consumer always ready
    for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Stall and skid: 0x33 must be held off until a slot frees
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous fire while holding one entry
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush beats both handshakes
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h88, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-traffic, asserted between edges
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_OutValid", OutValid, 1'b0);
    chk("midrst_InReady",  InReady,  1'b1);
    chk("midrst_Count",    Count,    2'd0);
    chk("midrst_OutData",  OutData,  8'h00);
    #1;
    reset = 1'b0;
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Random stress
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/flopskid.md
# flopskid

Two-entry ready/valid register slice (skid buffer) for the generic library: the handshaked counterpart of the plain D flip-flop. It accepts words from an upstream producer and delivers them to a downstream consumer, registering both the data/valid path and the ready path so that neither crosses the slice combinationally. It goes between pipeline stages or bus segments where a stall signal must be retimed without losing throughput.

## Interface
- WIDTH, 8, data word width in bits.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- FlushS  input  1  synchronous flush; discards all held entries.
- InValid  input  1  upstream offers InData this cycle.
- InReady  output  1  slice accepts a word this cycle; driven directly from a flop.
- InData  input  WIDTH  upstream word.
- OutValid  output  1  OutData holds a valid word; driven directly from a flop.
- OutReady  input  1  downstream takes OutData this cycle.
- OutData  output  WIDTH  head word; driven directly from the main data register.
- Count  output  2  number of held entries (0, 1 or 2).

## Operation
- Storage: main register (head, drives OutData) and skid register, each with a valid bit.
- Input fire: InValid & InReady. Output fire: OutValid & OutReady.
- States: EMPTY (none valid), ONE (main valid), TWO (main and skid valid).
- OutValid = state != EMPTY. InReady = state != TWO. Count = 0, 1 or 2 per state.
- EMPTY: input fire -> main <= InData, go to ONE; otherwise stay.
- ONE, input fire and output fire -> main <= InData, stay ONE.
- ONE, input fire only -> skid <= InData, go to TWO.
- ONE, output fire only -> go to EMPTY.
- ONE, neither -> hold.
- TWO: input fire is impossible because InReady = 0. Output fire -> main <= skid, go to ONE; otherwise hold.
- InValid while InReady = 0 is ignored. InData is not captured.
- Order is strictly FIFO. No word is duplicated or dropped except by FlushS or reset.
- While OutValid & !OutReady, OutData and OutValid are held stable.
- FlushS = 1 has priority over every handshake. On the next edge the state is EMPTY (OutValid 0, InReady 1, Count 0). Input and output fires in that cycle are discarded, and the consumer must treat them as not taken. Data registers are not modified.
- Reset asserted at any time, including mid-transfer, immediately forces:
  - state EMPTY: OutValid 0, InReady 1, Count 0;
  - main and skid data registers to 0.
  All held words are lost.

## Timing
- Latency: a word accepted at edge N is visible on OutData/OutValid after edge N, i.e. one cycle, when the slice is EMPTY or ONE with a simultaneous output fire.
- Throughput: one word per cycle sustained while OutReady = 1.
- Retiming: InReady deasserts one cycle after a stall begins. The second (skid) entry absorbs the word already in flight.
- Recovery: after one output fire from TWO, InReady reasserts on the following cycle.
- Combinational paths: none from any input to any output. All outputs come from flops.

## Test plan
- Reset mid-traffic:
  - fill to TWO (words 0xA1, 0xA2), then pulse reset between edges;
  - required: OutValid 0, InReady 1, Count 0, OutData 0x00 immediately, without waiting for an edge;
  - required: next accepted word 0x33 appears after one cycle.
- Streaming: InValid = 1 with words 0x01..0x10 on consecutive cycles, OutReady = 1:
  - required: OutData presents 0x01..0x10, one per cycle, one cycle behind input;
  - required: InReady stays 1 and Count stays 1 throughout.
- Stall and skid:
  - send 0x11, 0x22, 0x33 back to back with OutReady = 0;
  - required: Count goes 1 then 2, InReady drops to 0 after 0x22 is accepted, and 0x33 is held off upstream;
  - release OutReady: required order out is 0x11, 0x22, 0x33, with 0x11 stable during the stall.
- Simultaneous fire in ONE:
  - main holds 0x44; InValid = 1 with 0x55 and OutReady = 1 in the same cycle;
  - required: next OutData 0x55, Count stays 1.
- Flush over handshake:
  - state TWO (0x66, 0x77); assert FlushS together with OutReady = 1 and InValid = 1;
  - required: next cycle OutValid 0, Count 0, InReady 1;
  - required: a later input 0x88 is the next word out.
- Random stress: random InValid/OutReady for 10k cycles checked against a scoreboard queue.
  - required: no loss, duplication or reordering;
  - required: Count always equals the scoreboard depth, which never exceeds 2.
